// File: rtl/jellyvl_stream_frame_gen.sv
// Control-stream source: emits a programmed train of first/enable/last framed beats
// with valid/ready handshake. No payload, only frame and beat indices.
//
// state | meaning
// IDLE  | waiting for start, outputs quiet
// RUN   | presenting beats of the current frame
// GAP   | idle cycles between frames, down-counter to terminal count 1
// FIN   | run complete, emits the done pulse and drops busy
module jellyvl_stream_frame_gen #(
  parameter int NUMBER_WIDTH = 8,
  parameter int COUNT_WIDTH  = 16,
  parameter int GAP_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cke,
  input  logic                    start,
  input  logic [NUMBER_WIDTH-1:0] param_number,
  input  logic [COUNT_WIDTH-1:0]  param_length,
  input  logic [COUNT_WIDTH-1:0]  param_offset,
  input  logic [COUNT_WIDTH-1:0]  param_window,
  input  logic [GAP_WIDTH-1:0]    param_gap,
  output logic                    busy,
  output logic                    done,
  output logic [NUMBER_WIDTH-1:0] stream_number,
  output logic [COUNT_WIDTH-1:0]  stream_count,
  output logic                    stream_first,
  output logic                    stream_last,
  output logic                    stream_enable,
  output logic                    stream_valid,
  input  logic                    stream_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [NUMBER_WIDTH-1:0] num_lat;
  logic [COUNT_WIDTH-1:0]  len_lat, off_lat, win_lat;
  logic [GAP_WIDTH-1:0]    gap_lat;
  logic [GAP_WIDTH-1:0]    gap_cnt, gap_cnt_next;
  logic                    latch_en;

  logic                    busy_next, done_next, valid_next, first_next;
  logic                    last_next, enable_next;
  logic [NUMBER_WIDTH-1:0] number_next;
  logic [COUNT_WIDTH-1:0]  count_next;

  // parameters seen by the flag logic: live inputs on the start edge, latched copies afterwards
  logic [COUNT_WIDTH-1:0]  len_eff, off_eff, win_eff;

  logic                    xfer;
  logic                    final_frame;

  // window test done one bit wider so count-offset cannot alias
  function automatic logic calc_enable(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic [COUNT_WIDTH-1:0] off,
    input logic [COUNT_WIDTH-1:0] win
  );
    logic [COUNT_WIDTH:0] diff;
    diff = {1'b0, cnt} - {1'b0, off};
    return ({1'b0, cnt} >= {1'b0, off}) && (diff < {1'b0, win});
  endfunction

  assign xfer        = stream_valid && stream_ready;
  assign final_frame = (stream_number == (num_lat - NUMBER_WIDTH'(1)));

  always_comb begin
    len_eff = len_lat;
    off_eff = off_lat;
    win_eff = win_lat;
    if (state == ST_IDLE) begin
      len_eff = param_length;
      off_eff = param_offset;
      win_eff = param_window;
    end
  end

  always_comb begin
    state_next   = state;
    busy_next    = busy;
    done_next    = 1'b0;
    valid_next   = stream_valid;
    first_next   = stream_first;
    number_next  = stream_number;
    count_next   = stream_count;
    gap_cnt_next = gap_cnt;
    latch_en     = 1'b0;

    case (state)
      ST_IDLE: begin
        valid_next = 1'b0;
        if (start) begin
          latch_en  = 1'b1;
          busy_next = 1'b1;
          if ((param_number == '0) || (param_length == '0)) begin
            state_next = ST_FIN;
          end else begin
            state_next  = ST_RUN;
            valid_next  = 1'b1;
            number_next = '0;
            count_next  = '0;
            first_next  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (xfer) begin
          if (stream_last) begin
            if (final_frame) begin
              state_next = ST_FIN;
              valid_next = 1'b0;
            end else if (gap_lat == '0) begin
              number_next = stream_number + NUMBER_WIDTH'(1);
              count_next  = '0;
              first_next  = 1'b1;
            end else begin
              state_next   = ST_GAP;
              valid_next   = 1'b0;
              gap_cnt_next = gap_lat;
            end
          end else begin
            count_next = stream_count + COUNT_WIDTH'(1);
            first_next = 1'b0;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == GAP_WIDTH'(1)) begin
          state_next  = ST_RUN;
          valid_next  = 1'b1;
          number_next = stream_number + NUMBER_WIDTH'(1);
          count_next  = '0;
          first_next  = 1'b1;
        end else begin
          gap_cnt_next = gap_cnt - GAP_WIDTH'(1);
        end
      end

      ST_FIN: begin
        state_next = ST_IDLE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        valid_next = 1'b0;
      end

      default: begin
        state_next = ST_IDLE;
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase

    // flags always describe the beat about to be presented; quiet when nothing is presented
    last_next   = valid_next && (count_next == (len_eff - COUNT_WIDTH'(1)));
    enable_next = valid_next && calc_enable(count_next, off_eff, win_eff);
    first_next  = valid_next && first_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      stream_valid  <= 1'b0;
      stream_first  <= 1'b0;
      stream_last   <= 1'b0;
      stream_enable <= 1'b0;
      stream_number <= '0;
      stream_count  <= '0;
      gap_cnt       <= '0;
      num_lat       <= '0;
      len_lat       <= '0;
      off_lat       <= '0;
      win_lat       <= '0;
      gap_lat       <= '0;
    end else if (cke) begin
      state         <= state_next;
      busy          <= busy_next;
      done          <= done_next;
      stream_valid  <= valid_next;
      stream_first  <= first_next;
      stream_last   <= last_next;
      stream_enable <= enable_next;
      stream_number <= number_next;
      stream_count  <= count_next;
      gap_cnt       <= gap_cnt_next;
      if (latch_en) begin
        num_lat <= param_number;
        len_lat <= param_length;
        off_lat <= param_offset;
        win_lat <= param_window;
        gap_lat <= param_gap;
      end
    end
  end

endmodule

// File: doc/jellyvl_stream_frame_gen.md
Name: jellyvl_stream_frame_gen

Overview:
- Transmitter side of the first/enable/valid stream-control protocol used by the stream position logic.
- Generates a programmed train of frames. Each frame has a first marker, an enable window, a last marker and an optional idle gap.
- Sits upstream of position/window consumers. It serves as the control-stream source in pipelines and as the reference stimulus source in benches.
- Payload-free: it emits control plus frame/beat indices only, with valid/ready backpressure.

Parameters:
- NUMBER_WIDTH, 8: width of frame-count register and stream_number output.
- COUNT_WIDTH, 16: width of beat counter, length, offset and window parameters.
- GAP_WIDTH, 8: width of the inter-frame idle-cycle parameter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- cke  input  1  clock enable; when 0, all state and outputs hold.
- start  input  1  pulse; accepted only in IDLE.
- param_number  input  NUMBER_WIDTH  frames per run.
- param_length  input  COUNT_WIDTH  beats per frame.
- param_offset  input  COUNT_WIDTH  first enabled beat index within a frame.
- param_window  input  COUNT_WIDTH  number of enabled beats.
- param_gap  input  GAP_WIDTH  idle cycles between frames.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the run completes.
- stream_number  output  NUMBER_WIDTH  current frame index, 0-based.
- stream_count  output  COUNT_WIDTH  beat index within the frame.
- stream_first  output  1  beat 0 of a frame.
- stream_last  output  1  beat length-1 of a frame.
- stream_enable  output  1  beat lies inside the enable window.
- stream_valid  output  1  beat present.
- stream_ready  input  1  downstream accepts the beat.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, done=0, stream_valid=0, stream_first=0, stream_last=0, stream_enable=0.
  - stream_number=0, stream_count=0.
- Clock enable: all outputs are registered. With cke=0 nothing changes, including the done pulse width (done stays high until the next cke=1 edge).
- Parameter latch: parameters are latched on start acceptance. Later changes to param_* have no effect until the next run.
- FSM states: IDLE, RUN, GAP, FIN.
  - IDLE + start, with param_number==0 or param_length==0: go to FIN. No beats are emitted.
  - IDLE + start, otherwise: go to RUN. busy=1 and stream_valid=1 on the next edge, with number=0, count=0, first=1.
  - RUN, beat transfer: a beat transfers on valid&ready. Without a transfer, all stream_* outputs hold stable (no retraction, no change).
  - RUN, transfer of a non-last beat: count+1; first=0.
  - RUN, transfer of the last beat, final frame (number==param_number-1): go to FIN; valid=0.
  - RUN, transfer of the last beat, more frames remain, gap==0: stay in RUN. The next frame starts back-to-back with number+1, count=0, first=1.
  - RUN, transfer of the last beat, more frames remain, gap>0: go to GAP; valid=0.
  - GAP: stays exactly param_gap cycles (cke-qualified), then goes to RUN with number+1, count=0, first=1.
  - FIN: done=1 for one cycle; busy=0 on that same edge; then go to IDLE.
- start while not IDLE: ignored.
- Derived flags (computed for the beat being presented):
  - last = (count == length-1).
  - enable = (count >= offset) && ((count - offset) < window), compared at COUNT_WIDTH+1 bits. offset+window may exceed length; the window is then clipped at the frame end.
  - window==0 or offset>=length gives enable=0 for the entire frame.
- Single-beat frames: length==1 gives first=1 and last=1 on the same beat.
- Reset mid-run: everything aborts immediately to the reset values. No done pulse is produced.
- Throughput: 1 beat/cycle when ready=1 and gap==0. Start-to-first-valid latency is 1 cycle. Last-beat transfer to done is 1 cycle.

Test Plan:
- number=2, length=4, offset=1, window=2, gap=0, ready=1 -> 8 consecutive valid beats, counts 0,1,2,3,0,1,2,3. first on beats 0 and 4; last on beats 3 and 7; enable on counts 1,2. stream_number 0,0,0,0,1,1,1,1. done one cycle after beat 7.
- Same run with ready toggled 1,0,0,1,... -> no beat lost or duplicated. Outputs stable while ready=0. Total of 8 transfers.
- number=3, length=1, gap=2 -> each beat has first=last=1. Exactly 2 valid-low cycles between frames. done after the third beat.
- offset=3, window=5, length=4 -> enable only at count 3, the window clipped at the frame end. window=0 -> enable never asserted.
- number=0 or length=0 -> no valid. done pulses 2 cycles after start; busy high for exactly 1 cycle.
- Assert reset=0 mid-frame at count 2 -> valid=0, busy=0, no done. A new start afterwards begins again at number=0, count=0. A start pulsed during RUN is ignored.
